// File: rtl/gyro_sched_pkg.sv
// Shared types and constants for the gyro sample scheduler.
package gyro_sched_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_TICK = 2'd1,
    READ      = 2'd2,
    EMIT      = 2'd3
  } sched_state_e;

  localparam int unsigned ERR_CNT_MAX = 255;
  localparam int unsigned RAW_W       = 16;

  function automatic int unsigned bias_acc_w(input int unsigned log2n);
    return RAW_W + log2n;
  endfunction

endpackage

// File: rtl/gyro_sample_sched_tick.sv
// Free-running sample-period divider; emits a one-cycle tick on the last count.
module sample_tick_gen #(
  parameter int unsigned SAMPLE_DIV = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SAMPLE_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (en && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  assign tick = en && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gyro_sample_sched.sv
// Periodic gyro read scheduler with timeout, error counting and overrun flag.
// Define GYRO_BIAS_CAL_EN to average the first 2^BIAS_LOG2 reads into bias_*.
module gyro_sample_sched
  import gyro_sched_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV  = 1000,
  parameter int unsigned TIMEOUT_CYC = 500,
  parameter int unsigned BIAS_LOG2   = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    rd_req,
  input  logic                    rd_done,
  input  logic                    rd_err,
  input  logic signed [RAW_W-1:0] gx_raw,
  input  logic signed [RAW_W-1:0] gy_raw,
  input  logic signed [RAW_W-1:0] gz_raw,
  output logic                    cal_gyro_en,
  output logic                    busy,
  output logic [7:0]              err_cnt,
  output logic                    overrun,
  output logic signed [RAW_W-1:0] bias_x,
  output logic signed [RAW_W-1:0] bias_y,
  output logic signed [RAW_W-1:0] bias_z,
  output logic                    bias_valid
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0] ERR_MAX = 8'(ERR_CNT_MAX);

  sched_state_e state_q, state_d;
  logic [TO_W-1:0] to_q, to_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic overrun_q, overrun_d;
  logic bias_valid_q, bias_valid_d;
  logic tick;
  logic err_inc;
  logic rd_ok;
  logic cal_phase;

  sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (start),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    to_d      = '0;
    err_inc   = 1'b0;
    rd_ok     = 1'b0;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: if (start) state_d = WAIT_TICK;
      WAIT_TICK: begin
        if (!start)    state_d = IDLE;
        else if (tick) state_d = READ;
      end
      READ: begin
        if (tick) overrun_d = 1'b1;
        // rd_err wins over a simultaneous rd_done
        if (rd_err || (!rd_done && (to_q == TO_LAST))) begin
          err_inc = 1'b1;
          state_d = start ? WAIT_TICK : IDLE;
        end else if (rd_done) begin
          rd_ok   = 1'b1;
          state_d = cal_phase ? (start ? WAIT_TICK : IDLE) : EMIT;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      EMIT: begin
        if (tick) overrun_d = 1'b1;
        state_d = start ? WAIT_TICK : IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_cnt_d = (err_inc && (err_cnt_q != ERR_MAX)) ? err_cnt_q + 1'b1 : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      to_q         <= '0;
      err_cnt_q    <= '0;
      overrun_q    <= 1'b0;
      bias_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      to_q         <= to_d;
      err_cnt_q    <= err_cnt_d;
      overrun_q    <= overrun_d;
      bias_valid_q <= bias_valid_d;
    end
  end

  assign rd_req      = (state_q == READ);
  assign cal_gyro_en = (state_q == EMIT);
  assign busy        = (state_q != IDLE);
  assign err_cnt     = err_cnt_q;
  assign overrun     = overrun_q;
  assign bias_valid  = bias_valid_q;

`ifdef GYRO_BIAS_CAL_EN
  localparam int unsigned ACC_W = bias_acc_w(BIAS_LOG2);

  logic signed [RAW_W-1:0] raw [3];
  logic signed [ACC_W-1:0] acc_q [3];
  logic signed [ACC_W-1:0] acc_d [3];
  logic signed [RAW_W-1:0] bias_q [3];
  logic signed [RAW_W-1:0] bias_d [3];
  logic [BIAS_LOG2-1:0] cal_cnt_q, cal_cnt_d;

  assign raw[0]    = gx_raw;
  assign raw[1]    = gy_raw;
  assign raw[2]    = gz_raw;
  assign cal_phase = !bias_valid_q;

  // Bias is taken from the sum including the final sample, floor division.
  always_comb begin
    acc_d        = acc_q;
    bias_d       = bias_q;
    cal_cnt_d    = cal_cnt_q;
    bias_valid_d = bias_valid_q;
    if (rd_ok && cal_phase) begin
      cal_cnt_d = cal_cnt_q + 1'b1;
      for (int unsigned i = 0; i < 3; i++) begin
        acc_d[i] = acc_q[i] + ACC_W'(raw[i]);
        if (cal_cnt_q == '1) bias_d[i] = RAW_W'(acc_d[i] >>> BIAS_LOG2);
      end
      if (cal_cnt_q == '1) bias_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt_q <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        acc_q[i]  <= '0;
        bias_q[i] <= '0;
      end
    end else begin
      cal_cnt_q <= cal_cnt_d;
      for (int unsigned i = 0; i < 3; i++) begin
        acc_q[i]  <= acc_d[i];
        bias_q[i] <= bias_d[i];
      end
    end
  end

  assign bias_x = bias_q[0];
  assign bias_y = bias_q[1];
  assign bias_z = bias_q[2];
`else
  logic unused_raw;

  assign unused_raw   = ^{gx_raw, gy_raw, gz_raw, BIAS_LOG2[0]};
  assign cal_phase    = 1'b0;
  assign bias_valid_d = 1'b1;
  assign bias_x       = '0;
  assign bias_y       = '0;
  assign bias_z       = '0;
`endif

endmodule

// File: doc/gyro_sample_sched.md
GYRO_SAMPLE_SCHED -- requirements
Module: gyro_sample_sched

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 1000, clk cycles per gyro sample period (>=4).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 500, max clk cycles rd_req may wait for rd_done/rd_err (>=2).
REQ-003 SHALL have parameter BIAS_LOG2, default 6, log2 of bias-calibration sample count (1..8).
REQ-004 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  level; 1 = run periodic sampling.
REQ-007 SHALL have port rd_req  out  1  level request to MPU read engine.
REQ-008 SHALL have port rd_done  in  1  one-cycle pulse: gx/gy/gz_raw valid.
REQ-009 SHALL have port rd_err  in  1  one-cycle pulse: read failed.
REQ-010 SHALL have ports gx_raw, gy_raw, gz_raw  in  16 signed each  raw rate, valid with rd_done.
REQ-011 SHALL have port cal_gyro_en  out  1  one-cycle integration-enable pulse.
REQ-012 SHALL have port busy  out  1  high in any state except IDLE.
REQ-013 SHALL have port err_cnt  out  8  saturating count of timeouts plus rd_err.
REQ-014 SHALL have port overrun  out  1  sticky; a tick arrived during READ.
REQ-015 SHALL have ports bias_x, bias_y, bias_z  out  16 signed, and bias_valid  out  1.

Function
REQ-016 SHALL implement states IDLE, WAIT_TICK, READ, EMIT.
REQ-017 Tick counter SHALL run 0..SAMPLE_DIV-1 while start=1, wrap to 0, tick at SAMPLE_DIV-1; held at 0 while start=0.
REQ-018 IDLE->WAIT_TICK when start=1; WAIT_TICK->READ on tick.
REQ-019 rd_req SHALL be 1 exactly while in READ; it drops the cycle after rd_done, rd_err or timeout is sampled.
REQ-020 READ timeout SHALL fire when TIMEOUT_CYC cycles elapse without rd_done/rd_err; READ->WAIT_TICK, err_cnt+1.
REQ-021 rd_err in READ SHALL give READ->WAIT_TICK, err_cnt+1; rd_done and rd_err in same cycle SHALL count as rd_err.
REQ-022 rd_done in READ SHALL give READ->EMIT; EMIT SHALL assert cal_gyro_en for one cycle (1 cycle after rd_done), then ->WAIT_TICK.
REQ-023 A tick while in READ or EMIT SHALL set overrun and be dropped, never queued.
REQ-024 start=0 in WAIT_TICK SHALL give ->IDLE; in READ/EMIT the current read completes, then ->IDLE.
REQ-025 err_cnt SHALL saturate at 255; cleared only by reset.
REQ-026 rd_done/rd_err outside READ SHALL be ignored.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, tick counter 0, rd_req 0, cal_gyro_en 0, err_cnt 0, overrun 0, bias_* 0, bias_valid 0, accumulators 0.
REQ-028 Reset mid-READ SHALL abort the read with no pulse and no error count.

Configuration
REQ-029 With GYRO_BIAS_CAL_EN defined: the first 2^BIAS_LOG2 successful reads after reset SHALL be accumulated into (16+BIAS_LOG2)-bit signed accumulators, with no cal_gyro_en pulse during this phase.
REQ-030 With GYRO_BIAS_CAL_EN: after the final sample, bias = accumulator >>> BIAS_LOG2 (arithmetic, floor), bias_valid=1 sticky; later reads pulse normally; failed reads are not counted.
REQ-031 Without GYRO_BIAS_CAL_EN: no accumulators; bias_* SHALL be constant 0, bias_valid constant 1 from reset release; every rd_done pulses.

Structure
REQ-032 Package gyro_sched_pkg SHALL hold the state enum, ERR_CNT_MAX=255 and bias width constants.
REQ-033 Tick counter SHALL be sub-module sample_tick_gen (ports clk, rst_n, en, tick).

Verification (SAMPLE_DIV=10, TIMEOUT_CYC=5, BIAS_LOG2=2)
REQ-034 Macro off; start=1; rd_done 3 cycles after rd_req rise -> cal_gyro_en one cycle after each rd_done, pulses spaced exactly 10 cycles, err_cnt=0.
REQ-035 rd_done never given -> rd_req high 5 cycles then low, err_cnt=1, no cal_gyro_en; 300 timeouts -> err_cnt=255.
REQ-036 TIMEOUT_CYC=15, rd_done 12 cycles after rd_req -> overrun=1, pulse still issued, next READ on following tick.
REQ-037 Macro on; gx_raw 100,102,98,104, gz_raw -3,-3,-3,-4 -> bias_x=101, bias_z=-4, bias_valid=1, first cal_gyro_en on 5th rd_done.
REQ-038 rst_n low 2 cycles mid-READ -> rd_req, busy, cal_gyro_en 0 without waiting for clk edge; err_cnt 0; restart on start=1.
REQ-039 rd_done and rd_err same cycle -> err_cnt+1, no pulse; start=0 mid-READ -> read completes, pulse, then IDLE.
